core_scheduler: RTL and testbench

Row-level work dispatcher for the N-core matrix multiplier. On a start request it hands result-row indices `0..num_rows-1` to `N_CORES` instances of `single_core_processor`. Each row goes to the lowest-numbered free core; the block drives that core's `status` level and collects its `end_process`. It signals completion when every row has finished. It sits between the top-level control/host interface and the core array.

---
 rtl/matmul_sched_pkg.sv | 19 +
 rtl/free_core_pick.sv | 23 ++
 rtl/core_scheduler.sv | 149 ++++++++++++++
 tb/tb_core_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sched_pkg.sv
// Shared types and constants for the matrix-multiplier row scheduler.
package matmul_sched_pkg;

    // Scheduler control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } sched_state_e;

    localparam int unsigned DEF_N_CORES  = 4;
    localparam int unsigned DEF_MAX_ROWS = 16;

    // Bit offset of a core's row field inside the packed core_row bus (core0 in LSBs).
    function automatic int unsigned row_lsb(input int unsigned core, input int unsigned row_w);
        return core * row_w;
    endfunction

endpackage

// File: rtl/free_core_pick.sv
// Lowest-index priority encoder over the free-core mask.
module free_core_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_free,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_free[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Dispatches result-row indices to a pool of processor cores and tracks completion.
module core_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int unsigned N_CORES  = DEF_N_CORES,
    parameter int unsigned MAX_ROWS = DEF_MAX_ROWS,
    parameter int unsigned ROW_W    = $clog2(MAX_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W:0]           num_rows,
    input  logic [N_CORES-1:0]       core_end,
    output logic [N_CORES-1:0]       core_status,
    output logic [N_CORES*ROW_W-1:0] core_row,
    output logic                     busy,
    output logic                     done,
    output logic [ROW_W:0]           rows_done
);

    localparam int unsigned   IDX_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [ROW_W:0] ROWS_CAP = (ROW_W + 1)'(MAX_ROWS);
    localparam logic [ROW_W:0] ONE      = {{ROW_W{1'b0}}, 1'b1};

    sched_state_e               r_state,     w_state_nxt;
    logic [N_CORES-1:0]         r_status,    w_status_nxt;
    logic [N_CORES*ROW_W-1:0]   r_row,       w_row_nxt;
    logic                       r_busy,      w_busy_nxt;
    logic                       r_done,      w_done_nxt;
    logic [ROW_W:0]             r_rows_done, w_rows_done_nxt;
    logic [ROW_W:0]             r_next_row,  w_next_row_nxt;
    logic [ROW_W:0]             r_num_rows,  w_num_rows_nxt;

    logic [N_CORES-1:0]         w_free;
    logic                       w_found;
    logic [IDX_W-1:0]           w_idx;
    logic [N_CORES-1:0]         w_ends;
    logic [ROW_W:0]             w_end_cnt;
    logic [ROW_W:0]             w_num_clamped;

    // A core that is clearing this edge still shows status high, so it is not free yet.
    assign w_free        = ~r_status;
    assign w_ends        = r_status & core_end;
    assign w_num_clamped = (num_rows > ROWS_CAP) ? ROWS_CAP : num_rows;

    free_core_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_free  (w_free),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // Count how many running cores report completion on this edge.
    always_comb begin
        w_end_cnt = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            w_end_cnt = w_end_cnt + {{ROW_W{1'b0}}, w_ends[i]};
        end
    end

    // Next-state logic: job accept, dispatch, completion tracking.
    always_comb begin
        w_state_nxt     = r_state;
        w_status_nxt    = r_status;
        w_row_nxt       = r_row;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_rows_done_nxt = r_rows_done;
        w_next_row_nxt  = r_next_row;
        w_num_rows_nxt  = r_num_rows;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rows_done_nxt = '0;
                    if (w_num_clamped == '0) begin
                        // Empty job completes immediately without ever going busy.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_num_rows_nxt = w_num_clamped;
                        w_next_row_nxt = '0;
                        w_busy_nxt     = 1'b1;
                        w_state_nxt    = S_RUN;
                    end
                end
            end

            S_RUN, S_DRAIN: begin
                w_status_nxt    = r_status & ~w_ends;
                w_rows_done_nxt = r_rows_done + w_end_cnt;

                if (r_state == S_RUN && w_found) begin
                    for (int unsigned i = 0; i < N_CORES; i++) begin
                        if (w_idx == IDX_W'(i)) begin
                            w_status_nxt[i] = 1'b1;
                            w_row_nxt[row_lsb(i, ROW_W) +: ROW_W] = r_next_row[ROW_W-1:0];
                        end
                    end
                    w_next_row_nxt = r_next_row + ONE;
                    if (r_next_row + ONE == r_num_rows) begin
                        w_state_nxt = S_DRAIN;
                    end
                end

                if (w_rows_done_nxt == r_num_rows) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_status    <= '0;
            r_row       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rows_done <= '0;
            r_next_row  <= '0;
            r_num_rows  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_status    <= w_status_nxt;
            r_row       <= w_row_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rows_done <= w_rows_done_nxt;
            r_next_row  <= w_next_row_nxt;
            r_num_rows  <= w_num_rows_nxt;
        end
    end

    assign core_status = r_status;
    assign core_row    = r_row;
    assign busy        = r_busy;
    assign done        = r_done;
    assign rows_done   = r_rows_done;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler with a behavioural core-array model.
module tb_core_scheduler;
    import matmul_sched_pkg::*;

    localparam int NC = 4;
    localparam int MR = 16;
    localparam int RW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [RW:0]    num_rows;
    logic [NC-1:0]  core_end;
    logic [NC-1:0]  core_status;
    logic [NC*RW-1:0] core_row;
    logic           busy;
    logic           done;
    logic [RW:0]    rows_done;

    logic [NC-1:0]  model_end = '0;
    logic [NC-1:0]  force_end;
    logic           auto_en;
    int             lat;

    int             n_total = 0;
    int             n_bad   = 0;
    int             exp_rows[$];
    int             exp_done[$];
    int             done_cnt = 0;
    logic [NC-1:0]  used_mask = '0;
    logic [NC-1:0]  prev_st = '0;
    logic [NC-1:0]  prev_st_m = '0;
    logic           prev_done = 1'b0;
    logic [RW-1:0]  prev_row[NC];
    int             cnt[NC];

    always #5 clk = ~clk;

    assign core_end = (auto_en ? model_end : '0) | force_end;

    core_scheduler #(
        .N_CORES  (NC),
        .MAX_ROWS (MR),
        .ROW_W    (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_rows    (num_rows),
        .core_end    (core_end),
        .core_status (core_status),
        .core_row    (core_row),
        .busy        (busy),
        .done        (done),
        .rows_done   (rows_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Core model: each core raises end_process lat samples after its status rises.
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (core_status[i] && !prev_st_m[i]) cnt[i] = lat;
            else if (core_status[i] && cnt[i] > 0) cnt[i] = cnt[i] - 1;
            model_end[i] = core_status[i] && (cnt[i] == 0);
        end
        prev_st_m = core_status;
    end

    // Monitor: dispatch order/target, row stability, done pulses against the scoreboard.
    always @(negedge clk) begin
        logic [NC-1:0] rise;
        int lf;
        rise = core_status & ~prev_st;
        if (rise != '0) begin
            lf = -1;
            for (int i = NC - 1; i >= 0; i--) if (!prev_st[i]) lf = i;
            chk("one_disp", $countones(rise), 1);
            for (int i = 0; i < NC; i++) begin
                if (rise[i]) begin
                    chk("disp_core", i, lf);
                    if (exp_rows.size() == 0) chk("extra_disp", 1, 0);
                    else chk("disp_row", 32'(core_row[row_lsb(unsigned'(i), RW) +: RW]),
                             exp_rows.pop_front());
                end
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (prev_st[i] && core_status[i] &&
                core_row[row_lsb(unsigned'(i), RW) +: RW] != prev_row[i])
                chk("row_stable", 32'(core_row[row_lsb(unsigned'(i), RW) +: RW]),
                    32'(prev_row[i]));
        end
        if (core_status != '0 && !busy) chk("busy_run", 32'(busy), 1);
        if (done) begin
            done_cnt++;
            if (prev_done) chk("done_pulse", 1, 0);
            chk("done_busy", 32'(busy), 0);
            if (exp_done.size() == 0) chk("spurious_done", 1, 0);
            else chk("rows_done", 32'(rows_done), exp_done.pop_front());
        end
        for (int i = 0; i < NC; i++) prev_row[i] = core_row[row_lsb(unsigned'(i), RW) +: RW];
        prev_st   = core_status;
        prev_done = done;
        used_mask = used_mask | core_status;
    end

    task automatic start_job(input int n);
        int eff;
        @(negedge clk);
        num_rows = n[RW:0];
        start    = 1'b1;
        eff = (n > MR) ? MR : n;
        for (int r = 0; r < eff; r++) exp_rows.push_back(r);
        exp_done.push_back(eff);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int k;
        base = done_cnt;
        k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done_cnt - base, 1);
    endtask

    task automatic wait_status(input logic [NC-1:0] mask, input int budget);
        int k;
        k = 0;
        while (core_status != mask && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("status_reach", 32'(core_status), 32'(mask));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; num_rows = '0; force_end = '0; auto_en = 1'b1; lat = 10;
        repeat (3) @(negedge clk);
        chk("rst_status", 32'(core_status), 0);
        chk("rst_row", core_row, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rows", 32'(rows_done), 0);
        rst = 1'b0;

        // Three rows, 10-cycle cores: cores 0..2 on consecutive edges, core 3 unused.
        start_job(3);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_st0", 32'(core_status), 0);
        @(negedge clk); chk("t1_st1", 32'(core_status), 32'b0001);
        @(negedge clk); chk("t1_st2", 32'(core_status), 32'b0011);
        @(negedge clk); chk("t1_st3", 32'(core_status), 32'b0111);
        wait_done(100);
        @(negedge clk);
        chk("t1_used", 32'(used_mask), 32'b0111);
        chk("t1_rows", 32'(rows_done), 3);
        chk("t1_idle", 32'(busy), 0);

        // Ten rows over four 5-cycle cores.
        lat = 5;
        start_job(10);
        wait_done(300);
        @(negedge clk);
        chk("t2_rows", 32'(rows_done), 10);
        chk("t2_q", exp_rows.size(), 0);

        // Cores 1 and 3 finish together; next row must go to core 1.
        auto_en = 1'b0; lat = 3;
        start_job(5);
        wait_status(4'b1111, 10);
        force_end = 4'b1010;
        @(negedge clk);
        force_end = '0;
        chk("t3_drop", 32'(core_status), 32'b0101);
        chk("t3_cnt", 32'(rows_done), 2);
        @(negedge clk);
        chk("t3_redisp", 32'(core_status), 32'b0111);
        chk("t3_row1", 32'(core_row[RW +: RW]), 4);
        auto_en = 1'b1;
        wait_done(100);
        @(negedge clk);
        chk("t3_rows", 32'(rows_done), 5);

        // Empty job: done one cycle after start, never busy.
        start_job(0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 1);
        @(negedge clk);
        chk("t4_done_low", 32'(done), 0);
        chk("t4_busy2", 32'(busy), 0);
        chk("t4_st", 32'(core_status), 0);

        // Restart mid-job and end_process on an idle core are both ignored.
        lat = 8;
        start_job(2);
        @(negedge clk);
        @(negedge clk);
        force_end = 4'b1000; start = 1'b1; num_rows = 5'd5;
        @(negedge clk);
        force_end = '0; start = 1'b0;
        chk("t5_cnt", 32'(rows_done), 0);
        chk("t5_st", 32'(core_status), 32'b0011);
        chk("t5_busy", 32'(busy), 1);
        wait_done(100);
        @(negedge clk);
        chk("t5_rows", 32'(rows_done), 2);

        // Reset with all cores busy aborts the job without a done pulse.
        lat = 1000;
        start_job(8);
        wait_status(4'b1111, 10);
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_st", 32'(core_status), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rows0", 32'(rows_done), 0);
        chk("t6_done", 32'(done), 0);
        rst = 1'b0;
        exp_rows.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        chk("t6_nodone", done_cnt, base);
        lat = 4;
        start_job(3);
        wait_done(100);
        @(negedge clk);
        chk("t6_rows", 32'(rows_done), 3);

        chk("q_rows", exp_rows.size(), 0);
        chk("q_done", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
